// File: rtl/gray_counter_conv_if.sv
// Bus interface for gray_counter_conv.
//   master : drives counter controls and converter operands, observes results.
//   slave  : the gray_counter_conv block itself.
// Signals
//   en, up_dn, load, load_val              counter controls (master -> slave)
//   bin_q, gray_q, wrap, sat               counter state and flags (slave -> master)
//   cnv_valid, cnv_mode, cnv_in            converter operand (master -> slave)
//   cnv_out, cnv_ovalid                    converter result (slave -> master)
interface gray_counter_conv_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap;
    logic             sat;
    logic             cnv_valid;
    logic             cnv_mode;
    logic [WIDTH-1:0] cnv_in;
    logic [WIDTH-1:0] cnv_out;
    logic             cnv_ovalid;

    modport master (
        output en, up_dn, load, load_val, cnv_valid, cnv_mode, cnv_in,
        input  bin_q, gray_q, wrap, sat, cnv_out, cnv_ovalid
    );

    modport slave (
        input  en, up_dn, load, load_val, cnv_valid, cnv_mode, cnv_in,
        output bin_q, gray_q, wrap, sat, cnv_out, cnv_ovalid
    );
endinterface

// File: rtl/gray_counter_conv.sv
// gray_counter_conv
//   Registered Gray-code block with two independent functions:
//   - up/down counter publishing its value in binary and Gray form from the
//     same next-state value (no skew between the two), with wrap or saturate
//     behaviour selected by WRAP_EN;
//   - a one-cycle bidirectional Gray codec (binary->Gray or Gray->binary).
// Parameters
//   WIDTH   : counter / converter width (>= 2)
//   WRAP_EN : 1 = wrap at limits (wrap pulse), 0 = saturate at limits (sat level)
// Ports
//   clk : rising-edge clock
//   rst : asynchronous active-high reset, clears all state and outputs
//   bus : gray_counter_conv_if.slave (counter controls/state, converter in/out)
module gray_counter_conv #(
    parameter int WIDTH   = 4,
    parameter bit WRAP_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    gray_counter_conv_if.slave bus
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB down.
    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // True when a step in direction `up` would cross the counter range.
    function automatic logic at_limit(input logic [WIDTH-1:0] v, input logic up);
        return up ? (v == ALL_ONES) : (v == ZERO);
    endfunction

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] cnv_out_q, cnv_out_d;
    logic             cnv_ovalid_q, cnv_ovalid_d;

    // Counter next state: load > en > hold.
    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = bus.load_val;
        end else if (bus.en) begin
            if (at_limit(bin_q, bus.up_dn)) begin
                // In saturate mode the step is dropped and the value holds.
                if (WRAP_EN) begin
                    bin_d  = bus.up_dn ? ZERO : ALL_ONES;
                    wrap_d = 1'b1;
                end
            end else begin
                bin_d = bus.up_dn ? (bin_q + WIDTH'(1)) : (bin_q - WIDTH'(1));
            end
        end
        gray_d = bin2gray(bin_d);
        // sat reflects whether the registered value sits at the limit for the
        // direction currently requested.
        sat_d  = (WRAP_EN == 1'b0) && at_limit(bin_d, bus.up_dn);
    end

    // Converter operand stage: result captured only on a valid operand.
    always_comb begin
        cnv_out_d    = cnv_out_q;
        cnv_ovalid_d = bus.cnv_valid;
        if (bus.cnv_valid) begin
            cnv_out_d = bus.cnv_mode ? gray2bin(bus.cnv_in) : bin2gray(bus.cnv_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q        <= ZERO;
            gray_q       <= ZERO;
            wrap_q       <= 1'b0;
            sat_q        <= 1'b0;
            cnv_out_q    <= ZERO;
            cnv_ovalid_q <= 1'b0;
        end else begin
            bin_q        <= bin_d;
            gray_q       <= gray_d;
            wrap_q       <= wrap_d;
            sat_q        <= sat_d;
            cnv_out_q    <= cnv_out_d;
            cnv_ovalid_q <= cnv_ovalid_d;
        end
    end

    assign bus.bin_q      = bin_q;
    assign bus.gray_q     = gray_q;
    assign bus.wrap       = wrap_q;
    assign bus.sat        = sat_q;
    assign bus.cnv_out    = cnv_out_q;
    assign bus.cnv_ovalid = cnv_ovalid_q;

endmodule
